// File: rtl/pe_pkg.sv
// pe_pkg: message format and feeder FSM states shared by the PE array blocks.
package pe_pkg;
  localparam int BIT_WIDTH = 8;
  typedef struct packed {
    logic                 is_weight;
    logic [BIT_WIDTH-1:0] data;
  } PEMsg;
  typedef enum logic [2:0] {IDLE, WEIGHT, SKEW, STREAM, DONE} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: val/rdy synchronous FIFO with wrap-bit pointers.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_val,
  output logic             push_rdy,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_val,
  input  logic             pop_rdy
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]      wp, rp;
  logic [WIDTH-1:0] mem [DEPTH];
  assign push_rdy = !(wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0]);
  assign pop_val  = wp != rp;
  assign pop_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_val && push_rdy) wp <= wp + 1'b1;
      if (pop_val && pop_rdy) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (push_val && push_rdy) mem[wp[AW-1:0]] <= push_data;
endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: loads a row's weights, applies row skew, then streams buffered activations.
module pe_row_feeder #(
  parameter int BIT_WIDTH = pe_pkg::BIT_WIDTH,
  parameter int NUM_COLS  = 4,
  parameter int ROW_IDX   = 0,
  parameter int ACT_DEPTH = 8,
  parameter int CNT_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [CNT_W-1:0]     i_num_act,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic [BIT_WIDTH-1:0] i_wgt_recv,
  input  logic                 i_wgt_recv_val,
  output logic                 o_wgt_recv_rdy,
  input  logic [BIT_WIDTH-1:0] i_act_recv,
  input  logic                 i_act_recv_val,
  output logic                 o_act_recv_rdy,
  output pe_pkg::PEMsg         o_msg_send,
  output logic                 o_msg_send_val,
  input  logic                 i_msg_send_rdy
);
  import pe_pkg::*;
  localparam int WW = $clog2(NUM_COLS) + 1;
  state_e               state;
  logic [CNT_W-1:0]     num_act, act_cnt, skew_cnt;
  logic [WW-1:0]        wgt_cnt;
  logic [BIT_WIDTH-1:0] head;
  logic                 fifo_val, msg_hs;
  sync_fifo #(.WIDTH(BIT_WIDTH), .DEPTH(ACT_DEPTH)) u_fifo (
    .clk(i_clk), .rst(i_rst),
    .push_data(i_act_recv), .push_val(i_act_recv_val), .push_rdy(o_act_recv_rdy),
    .pop_data(head), .pop_val(fifo_val), .pop_rdy(state == STREAM && i_msg_send_rdy)
  );
  assign o_busy         = state != IDLE;
  assign o_done         = state == DONE;
  assign o_wgt_recv_rdy = state == WEIGHT && i_msg_send_rdy;
  assign o_msg_send_val = state == WEIGHT ? i_wgt_recv_val : state == STREAM && fifo_val;
  assign o_msg_send     = PEMsg'(state == WEIGHT ? {1'b1, i_wgt_recv} :
                                 state == STREAM ? {1'b0, head} : '0);
  assign msg_hs         = o_msg_send_val && i_msg_send_rdy;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      num_act  <= '0;
      act_cnt  <= '0;
      skew_cnt <= '0;
      wgt_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state   <= WEIGHT;
          num_act <= i_num_act;
          wgt_cnt <= '0;
          act_cnt <= '0;
        end
        WEIGHT: if (msg_hs) begin
          wgt_cnt <= wgt_cnt + 1'b1;
          if (wgt_cnt == WW'(NUM_COLS - 1)) begin
            state    <= ROW_IDX != 0 ? SKEW : num_act == '0 ? DONE : STREAM;
            skew_cnt <= CNT_W'(ROW_IDX - 1);
          end
        end
        // skew also freezes under PE backpressure so the row stays aligned
        SKEW: if (i_msg_send_rdy) begin
          skew_cnt <= skew_cnt - 1'b1;
          if (skew_cnt == '0) state <= num_act == '0 ? DONE : STREAM;
        end
        STREAM: if (msg_hs) begin
          act_cnt <= act_cnt + 1'b1;
          if (act_cnt == num_act - 1'b1) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: scoreboard bench for two feeder rows (skew 0 and skew 3).
module tb_pe_row_feeder;
  typedef struct {int cyc; logic [8:0] m;} rec_t;
  logic clk = 0, rst = 1, start = 0, sel = 0;
  logic [7:0] num_act = 0, wdat, adat;
  logic wval, aval, mrdy;
  logic busy0, done0, wrdy0, ardy0, mval0, busy3, done3, wrdy3, ardy3, mval3;
  pe_pkg::PEMsg m0, m3;
  logic busy, done, wrdy, ardy, mval;
  logic [8:0] msg;
  logic [7:0] wsrc[$], asrc[$];
  logic rdy_q[$];
  logic [8:0] exp_q[$];
  rec_t obs[$];
  int done_q[$];
  int cyc = 0, hold_err = 0, stalls = 0, n_cmp = 0, n_fail = 0;
  logic w_take, a_take, held = 0;
  logic [8:0] held_m;

  always #5 clk = ~clk;

  pe_row_feeder #(.ROW_IDX(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start && !sel), .i_num_act(num_act),
    .o_busy(busy0), .o_done(done0),
    .i_wgt_recv(wdat), .i_wgt_recv_val(wval), .o_wgt_recv_rdy(wrdy0),
    .i_act_recv(adat), .i_act_recv_val(aval && !sel), .o_act_recv_rdy(ardy0),
    .o_msg_send(m0), .o_msg_send_val(mval0), .i_msg_send_rdy(mrdy));
  pe_row_feeder #(.ROW_IDX(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start && sel), .i_num_act(num_act),
    .o_busy(busy3), .o_done(done3),
    .i_wgt_recv(wdat), .i_wgt_recv_val(wval), .o_wgt_recv_rdy(wrdy3),
    .i_act_recv(adat), .i_act_recv_val(aval && sel), .o_act_recv_rdy(ardy3),
    .o_msg_send(m3), .o_msg_send_val(mval3), .i_msg_send_rdy(mrdy));

  assign busy = sel ? busy3 : busy0;
  assign done = sel ? done3 : done0;
  assign wrdy = sel ? wrdy3 : wrdy0;
  assign ardy = sel ? ardy3 : ardy0;
  assign mval = sel ? mval3 : mval0;
  assign msg  = sel ? m3 : m0;

  // sources: hold data until the handshake seen at mid-cycle completes
  initial begin
    wval = 0; aval = 0; wdat = 0; adat = 0; mrdy = 1;
    forever begin
      @(negedge clk);
      w_take = wval && wrdy && !rst;
      a_take = aval && ardy && !rst;
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        wsrc.delete();
        asrc.delete();
      end else begin
        if (w_take && wsrc.size() != 0) void'(wsrc.pop_front());
        if (a_take && asrc.size() != 0) void'(asrc.pop_front());
      end
      wval = wsrc.size() != 0;
      wdat = wval ? wsrc[0] : 8'h0;
      aval = asrc.size() != 0;
      adat = aval ? asrc[0] : 8'h0;
      mrdy = rdy_q.size() != 0 ? rdy_q.pop_front() : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && mval && mrdy) obs.push_back('{cyc, msg});
    if (!rst && done) done_q.push_back(cyc);
    if (!rst && held && !(mval && msg === held_m)) hold_err++;
    held = !rst && mval && !mrdy;
    held_m = msg;
    if (held) stalls++;
  end

  function automatic rec_t at(int i);
    rec_t r;
    r.cyc = -1000;
    r.m = 'x;
    if (i < obs.size()) r = obs[i];
    return r;
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_pulse(logic [7:0] n);
    @(posedge clk); #2;
    start = 1; num_act = n;
    @(posedge clk); #2;
    start = 0;
  endtask

  task automatic wait_done(int d, output logic ok);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (done_q.size() > d) begin ok = 1; break; end
      @(posedge clk); #2;
    end
  endtask

  task automatic load_std();
    for (int i = 1; i <= 4; i++) begin
      wsrc.push_back(8'(i));
      exp_q.push_back({1'b1, 8'(i)});
    end
    asrc.push_back(8'd5); asrc.push_back(8'd6);
    exp_q.push_back({1'b0, 8'd5}); exp_q.push_back({1'b0, 8'd6});
  endtask

  task automatic test_reset();
    rst = 1;
    tick(3);
    rst = 0;
    n_cmp += 6;
    if (busy !== 0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 0) begin n_fail++; $display("FAIL reset done: got %b want 0", done); end
    if (mval !== 0) begin n_fail++; $display("FAIL reset msg_val: got %b want 0", mval); end
    if (wrdy !== 0) begin n_fail++; $display("FAIL reset wgt_rdy: got %b want 0", wrdy); end
    if (ardy !== 1) begin n_fail++; $display("FAIL reset act_rdy: got %b want 1", ardy); end
    if (msg !== 9'h0) begin n_fail++; $display("FAIL reset msg: got %h want 000", msg); end
  endtask

  task automatic test_basic();
    int b = obs.size(), d = done_q.size();
    logic ok;
    logic [8:0] e;
    sel = 0;
    load_std();
    tick(4);
    start_pulse(8'd2);
    n_cmp++;
    if (busy !== 1) begin n_fail++; $display("FAIL basic busy: got %b want 1", busy); end
    wait_done(d, ok);
    n_cmp++;
    if (ok !== 1) begin n_fail++; $display("FAIL basic done_timeout: got %b want 1", ok); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL basic msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    n_cmp += 2;
    if (at(b + 5).cyc - at(b).cyc != 5) begin n_fail++; $display("FAIL basic span: got %0d want 5", at(b + 5).cyc - at(b).cyc); end
    if (done_q[done_q.size() - 1] != at(b + 5).cyc + 1) begin n_fail++; $display("FAIL basic done_cycle: got %0d want %0d", done_q[done_q.size() - 1], at(b + 5).cyc + 1); end
    tick(3);
  endtask

  task automatic test_skew();
    int b = obs.size(), d = done_q.size();
    logic ok;
    logic [8:0] e;
    sel = 1;
    load_std();
    tick(4);
    start_pulse(8'd2);
    wait_done(d, ok);
    n_cmp++;
    if (ok !== 1) begin n_fail++; $display("FAIL skew done_timeout: got %b want 1", ok); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL skew msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    n_cmp += 3;
    if (at(b + 3).cyc - at(b).cyc != 3) begin n_fail++; $display("FAIL skew wgt_span: got %0d want 3", at(b + 3).cyc - at(b).cyc); end
    if (at(b + 4).cyc - at(b + 3).cyc != 4) begin n_fail++; $display("FAIL skew gap: got %0d want 4", at(b + 4).cyc - at(b + 3).cyc); end
    if (at(b + 5).cyc - at(b + 4).cyc != 1) begin n_fail++; $display("FAIL skew act_span: got %0d want 1", at(b + 5).cyc - at(b + 4).cyc); end
    tick(3);
    sel = 0;
  endtask

  task automatic test_backpressure();
    int b = obs.size(), d = done_q.size(), h0 = hold_err, s0 = stalls;
    logic ok;
    logic [8:0] e;
    sel = 0;
    load_std();
    tick(4);
    repeat (15) begin rdy_q.push_back(1); rdy_q.push_back(0); rdy_q.push_back(0); end
    start_pulse(8'd2);
    wait_done(d, ok);
    n_cmp++;
    if (ok !== 1) begin n_fail++; $display("FAIL bp done_timeout: got %b want 1", ok); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL bp msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    n_cmp += 3;
    if (obs.size() != b + 6) begin n_fail++; $display("FAIL bp count: got %0d want 6", obs.size() - b); end
    if (hold_err != h0) begin n_fail++; $display("FAIL bp hold: got %0d unstable want 0", hold_err - h0); end
    if (stalls == s0) begin n_fail++; $display("FAIL bp stalls: got 0 want >0"); end
    for (int k = 0; k < 100 && rdy_q.size() != 0; k++) tick(1);
    tick(2);
  endtask

  task automatic test_fifo_full();
    int b = obs.size(), d = done_q.size();
    logic ok, prev_rdy;
    logic [8:0] e;
    sel = 0;
    for (int i = 10; i <= 17; i++) asrc.push_back(8'(i));
    tick(12);
    n_cmp += 2;
    if (asrc.size() != 0) begin n_fail++; $display("FAIL full accepted: got %0d left want 0", asrc.size()); end
    if (ardy !== 0) begin n_fail++; $display("FAIL full act_rdy: got %b want 0", ardy); end
    for (int i = 1; i <= 4; i++) begin
      wsrc.push_back(8'(i));
      exp_q.push_back({1'b1, 8'(i)});
    end
    for (int i = 10; i <= 17; i++) exp_q.push_back({1'b0, 8'(i)});
    start_pulse(8'd8);
    prev_rdy = ardy;
    for (int k = 0; k < 50 && obs.size() < b + 5; k++) begin
      prev_rdy = ardy;
      tick(1);
    end
    n_cmp += 2;
    if (prev_rdy !== 0) begin n_fail++; $display("FAIL full rdy_before_pop: got %b want 0", prev_rdy); end
    if (ardy !== 1) begin n_fail++; $display("FAIL full rdy_after_pop: got %b want 1", ardy); end
    wait_done(d, ok);
    n_cmp++;
    if (ok !== 1) begin n_fail++; $display("FAIL full done_timeout: got %b want 1", ok); end
    for (int i = 0; i < 12; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL full msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    tick(3);
  endtask

  task automatic test_zero_act();
    int b = obs.size(), d = done_q.size();
    logic ok;
    logic [8:0] e;
    sel = 0;
    for (int i = 1; i <= 4; i++) begin
      wsrc.push_back(8'(20 + i));
      exp_q.push_back({1'b1, 8'(20 + i)});
    end
    repeat (8) rdy_q.push_back(0);
    start_pulse(8'd0);
    start = 1; num_act = 8'd5;
    tick(1);
    start = 0;
    wait_done(d, ok);
    n_cmp++;
    if (ok !== 1) begin n_fail++; $display("FAIL zero done_timeout: got %b want 1", ok); end
    tick(5);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL zero msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    n_cmp += 3;
    if (obs.size() != b + 4) begin n_fail++; $display("FAIL zero count: got %0d want 4", obs.size() - b); end
    if (done_q.size() != d + 1) begin n_fail++; $display("FAIL zero dones: got %0d want 1", done_q.size() - d); end
    if (busy !== 0) begin n_fail++; $display("FAIL zero busy_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int b = obs.size(), d;
    logic ok;
    logic [8:0] e;
    sel = 0;
    for (int i = 1; i <= 4; i++) begin
      wsrc.push_back(8'(i));
      exp_q.push_back({1'b1, 8'(i)});
    end
    for (int i = 5; i <= 7; i++) asrc.push_back(8'(i));
    exp_q.push_back({1'b0, 8'd5});
    tick(5);
    start_pulse(8'd3);
    for (int k = 0; k < 50 && obs.size() < b + 5; k++) tick(1);
    rst = 1;
    tick(1);
    n_cmp += 6;
    if (busy !== 0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", busy); end
    if (done !== 0) begin n_fail++; $display("FAIL midrst done: got %b want 0", done); end
    if (mval !== 0) begin n_fail++; $display("FAIL midrst msg_val: got %b want 0", mval); end
    if (wrdy !== 0) begin n_fail++; $display("FAIL midrst wgt_rdy: got %b want 0", wrdy); end
    if (ardy !== 1) begin n_fail++; $display("FAIL midrst act_rdy: got %b want 1", ardy); end
    if (msg !== 9'h0) begin n_fail++; $display("FAIL midrst msg: got %h want 000", msg); end
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL midrst pre_msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    n_cmp++;
    if (obs.size() != b + 5) begin n_fail++; $display("FAIL midrst pre_count: got %0d want 5", obs.size() - b); end
    b = obs.size();
    d = done_q.size();
    load_std();
    tick(4);
    start_pulse(8'd2);
    wait_done(d, ok);
    n_cmp++;
    if (ok !== 1) begin n_fail++; $display("FAIL midrst done_timeout: got %b want 1", ok); end
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (at(b + i).m !== e) begin n_fail++; $display("FAIL midrst msg[%0d]: got %h want %h", i, at(b + i).m, e); end
    end
    n_cmp += 2;
    if (at(b + 5).cyc - at(b).cyc != 5) begin n_fail++; $display("FAIL midrst span: got %0d want 5", at(b + 5).cyc - at(b).cyc); end
    if (done_q[done_q.size() - 1] != at(b + 5).cyc + 1) begin n_fail++; $display("FAIL midrst done_cycle: got %0d want %0d", done_q[done_q.size() - 1], at(b + 5).cyc + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skew();
    test_backpressure();
    test_fifo_full();
    test_zero_act();
    test_reset_mid();
    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
